load_store_buffer: RTL and testbench
====================================

LOAD_STORE_BUFFER -- requirements
Module: load_store_buffer

Interface
REQ-001 SHALL use one clock and synchronous active-high reset: clk, rst.
REQ-002 Ports (name direction width meaning):
- clk in 1: clock
- rst in 1: sync active-high reset
- rdy in 1: global enable; low freezes all state and outputs
- clear in 1: misprediction flush
- RS_valid in 1: entry offered by LSB reservation station
- RS_op in `OPBus: LB/LH/LW/LBU/LHU/SB/SH/SW
- RS_reg1 in 32: base
- RS_reg2 in 32: store data
- RS_imm in 32: offset
- RS_reg_des_rob in `TagBus: ROB tag
- LSB_is_full out 1: back-pressure to RS
- ROB_store_ready_valid/tag out 1/`TagBus: store address+data resolved
- ROB_commit_valid/tag in 1/`TagBus: ROB committing this tag
- mem_req_valid out 1: request held until mem_done
- mem_is_write out 1
- mem_addr out 32
- mem_wdata out 32
- mem_len out 2: 0=byte, 1=half, 2=word
- mem_done in 1: one-cycle completion pulse
- mem_rdata in 32: raw load data, zero-extended by controller
- LSB_cdb_valid/tag/data out 1/`TagBus/32: load result broadcast

Function
REQ-003 SHALL hold an 8-entry circular FIFO (head, tail, count 0..8); pointers wrap 7->0.
REQ-004 RS_valid with rdy SHALL write tail, advance tail, count+1; entries are never refused.
REQ-005 LSB_is_full SHALL be combinational, high when count>=7 (one slot slack for the RS one-cycle latency).
REQ-006 Per entry SHALL store op, addr = RS_reg1+RS_imm (mod 2^32, computed at accept), data = RS_reg2, tag, committed bit (0 at accept).
REQ-007 For stores, SHALL pulse ROB_store_ready_valid with the tag the cycle after accept.
REQ-008 ROB_commit_valid SHALL set committed on the valid store entry whose tag matches; a non-matching tag is ignored.
REQ-009 FSM states IDLE and BUSY; only the head entry issues; strictly in order.
REQ-010 IDLE->BUSY when head valid and (head is load, or head is store with committed=1); mem_req_valid rises the next cycle with addr, len, is_write, wdata.
REQ-011 mem_* outputs SHALL stay stable while mem_req_valid is high; BUSY->IDLE on mem_done, deasserting mem_req_valid the same edge.
REQ-012 On load mem_done SHALL register LSB_cdb_valid=1, tag, and data sign-extended (LB/LH) or zero-extended (LBU/LHU) from mem_rdata[7:0]/[15:0]; LW passes 32 bits; pulse lasts one cycle.
REQ-013 On mem_done SHALL pop head (head+1, count-1); accept and pop in the same cycle leave count unchanged.
REQ-014 Stores produce no CDB output.
REQ-015 Load latency: head valid in IDLE -> CDB valid = 2 cycles + memory latency.
REQ-016 clear SHALL invalidate every uncommitted entry, set tail = head + committed-prefix length, and deassert ROB_store_ready_valid and LSB_cdb_valid.
REQ-017 clear during an in-flight load SHALL drop mem_req_valid and go IDLE; during an in-flight committed store, the request continues to mem_done.
REQ-018 RS_valid coincident with clear SHALL be discarded.

Reset
REQ-019 rst SHALL set head=tail=count=0, all entries invalid, FSM IDLE, and every output 0 (LSB_is_full=0); rst overrides clear and rdy.

Verification
REQ-020 LW, reg1=0x100, imm=4, mem_rdata=0xDEADBEEF after 3 cycles -> mem_addr=0x104, len=2, CDB data 0xDEADBEEF with the same tag, one pulse.
REQ-021 LB then LBU, mem_rdata=0x00000080 -> CDB 0xFFFFFF80 then 0x00000080, in order.
REQ-022 SW tag 5, data 0x12345678 -> ROB_store_ready tag 5 next cycle; no mem_req until ROB_commit tag 5; then write of 0x12345678, len=2.
REQ-023 Accept 7 entries with memory stalled -> LSB_is_full=1 at count 7; an 8th accepted; pointer wrap over 20 entries preserves order.
REQ-024 Committed SW in flight plus two loads queued, clear -> store completes, loads never issue, no CDB output, count=0 after mem_done.
REQ-025 rst asserted mid-load -> next cycle all outputs 0, count=0, mem_req_valid=0.

Source files
------------

// File: rtl/load_store_buffer.sv
// Load/store buffer: 8-entry in-order queue between the LSB reservation station and memory.
// Loads issue when they reach the head; stores wait at the head until the ROB commits them.
module load_store_buffer #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear,
  input  logic             RS_valid,
  input  logic [2:0]       RS_op,
  input  logic [31:0]      RS_reg1,
  input  logic [31:0]      RS_reg2,
  input  logic [31:0]      RS_imm,
  input  logic [TAG_W-1:0] RS_reg_des_rob,
  output logic             LSB_is_full,
  output logic             ROB_store_ready_valid,
  output logic [TAG_W-1:0] ROB_store_ready_tag,
  input  logic             ROB_commit_valid,
  input  logic [TAG_W-1:0] ROB_commit_tag,
  output logic             mem_req_valid,
  output logic             mem_is_write,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [1:0]       mem_len,
  input  logic             mem_done,
  input  logic [31:0]      mem_rdata,
  output logic             LSB_cdb_valid,
  output logic [TAG_W-1:0] LSB_cdb_tag,
  output logic [31:0]      LSB_cdb_data,
  output logic             state_dbg,
  output logic [3:0]       count_dbg
);

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_LHU = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  function automatic logic is_store(input logic [2:0] op);
    return op >= OP_SB;
  endfunction

  function automatic logic [1:0] len_of(input logic [2:0] op);
    len_of = 2'd2;
    case (op)
      OP_LB, OP_LBU, OP_SB: len_of = 2'd0;
      OP_LH, OP_LHU, OP_SH: len_of = 2'd1;
      OP_LW, OP_SW:         len_of = 2'd2;
      default:              len_of = 2'd2;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] op, input logic [31:0] raw);
    case (op)
      OP_LB:   return {{24{raw[7]}}, raw[7:0]};
      OP_LH:   return {{16{raw[15]}}, raw[15:0]};
      OP_LBU:  return {24'd0, raw[7:0]};
      OP_LHU:  return {16'd0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  function automatic logic [2:0] slot(input logic [2:0] base, input int k);
    return base + k[2:0];
  endfunction

  logic [2:0]       op_q   [8];
  logic [31:0]      addr_q [8];
  logic [31:0]      data_q [8];
  logic [TAG_W-1:0] tag_q  [8];
  logic [7:0]       committed_q;
  logic [2:0]       head_q, tail_q;
  logic [3:0]       count_q;
  state_t           state_q, state_d;

  logic [7:0] entry_valid, committed_eff;
  logic [3:0] prefix;
  logic       run, accept, issue, done, head_is_store, head_committed, can_issue;

  assign accept         = RS_valid && !clear;
  assign head_is_store  = is_store(op_q[head_q]);
  assign head_committed = committed_q[head_q];
  assign can_issue      = (count_q != 4'd0) && (head_is_store ? head_committed : !clear);
  assign LSB_is_full    = count_q >= 4'd7;
  assign state_dbg      = state_q;
  assign count_dbg      = count_q;

  // Commits arriving alongside a flush still count toward the surviving committed prefix.
  always_comb begin
    entry_valid   = '0;
    committed_eff = committed_q;
    prefix        = '0;
    run           = 1'b1;
    for (int k = 0; k < 8; k++)
      if (k[3:0] < count_q) entry_valid[slot(head_q, k)] = 1'b1;
    for (int i = 0; i < 8; i++)
      if (ROB_commit_valid && entry_valid[i] && is_store(op_q[i]) && tag_q[i] == ROB_commit_tag)
        committed_eff[i] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (run && k[3:0] < count_q && committed_eff[slot(head_q, k)]) prefix = prefix + 4'd1;
      else run = 1'b0;
    end
  end

  always_comb begin
    state_d       = state_q;
    mem_req_valid = (state_q == BUSY);
    done          = (state_q == BUSY) && mem_done;
    issue         = 1'b0;
    case (state_q)
      IDLE: if (can_issue) begin
        state_d = BUSY;
        issue   = 1'b1;
      end
      BUSY: begin
        if (mem_done) state_d = IDLE;
        else if (clear && !head_is_store) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q               <= IDLE;
      head_q                <= '0;
      tail_q                <= '0;
      count_q               <= '0;
      committed_q           <= '0;
      ROB_store_ready_valid <= 1'b0;
      ROB_store_ready_tag   <= '0;
      mem_is_write          <= 1'b0;
      mem_addr              <= '0;
      mem_wdata             <= '0;
      mem_len               <= '0;
      LSB_cdb_valid         <= 1'b0;
      LSB_cdb_tag           <= '0;
      LSB_cdb_data          <= '0;
    end else if (rdy) begin
      state_q               <= state_d;
      committed_q           <= committed_eff;
      ROB_store_ready_valid <= accept && is_store(RS_op);
      LSB_cdb_valid         <= 1'b0;
      if (accept && is_store(RS_op)) ROB_store_ready_tag <= RS_reg_des_rob;
      if (issue) begin
        mem_addr     <= addr_q[head_q];
        mem_wdata    <= data_q[head_q];
        mem_is_write <= head_is_store;
        mem_len      <= len_of(op_q[head_q]);
      end
      if (done && !head_is_store && !clear) begin
        LSB_cdb_valid <= 1'b1;
        LSB_cdb_tag   <= tag_q[head_q];
        LSB_cdb_data  <= extend(op_q[head_q], mem_rdata);
      end
      // A flush keeps only the committed prefix; a finishing committed store still pops.
      if (clear) begin
        tail_q <= head_q + prefix[2:0];
        if (done && head_committed) begin
          head_q  <= head_q + 3'd1;
          count_q <= prefix - 4'd1;
        end else begin
          count_q <= prefix;
        end
      end else begin
        if (accept) begin
          op_q[tail_q]        <= RS_op;
          addr_q[tail_q]      <= RS_reg1 + RS_imm;
          data_q[tail_q]      <= RS_reg2;
          tag_q[tail_q]       <= RS_reg_des_rob;
          committed_q[tail_q] <= 1'b0;
        end
        tail_q  <= tail_q + {2'b0, accept};
        head_q  <= head_q + {2'b0, done};
        count_q <= count_q + {3'b0, accept} - {3'b0, done};
      end
    end
  end

endmodule

// File: tb/tb_load_store_buffer.sv
// Directed plus randomized bench for load_store_buffer against a transaction-level queue model.
module tb_load_store_buffer;
  localparam int TAG_W = 4;
  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3, LHU = 3'd4,
                         SB = 3'd5, SH = 3'd6, SW = 3'd7;

  logic             clk, rst, rdy, clear;
  logic             RS_valid;
  logic [2:0]       RS_op;
  logic [31:0]      RS_reg1, RS_reg2, RS_imm;
  logic [TAG_W-1:0] RS_reg_des_rob;
  logic             LSB_is_full;
  logic             ROB_store_ready_valid;
  logic [TAG_W-1:0] ROB_store_ready_tag;
  logic             ROB_commit_valid;
  logic [TAG_W-1:0] ROB_commit_tag;
  logic             mem_req_valid, mem_is_write;
  logic [31:0]      mem_addr, mem_wdata;
  logic [1:0]       mem_len;
  logic             mem_done;
  logic [31:0]      mem_rdata;
  logic             LSB_cdb_valid;
  logic [TAG_W-1:0] LSB_cdb_tag;
  logic [31:0]      LSB_cdb_data;
  logic             state_dbg;
  logic [3:0]       count_dbg;

  load_store_buffer #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .RS_valid(RS_valid), .RS_op(RS_op), .RS_reg1(RS_reg1), .RS_reg2(RS_reg2),
    .RS_imm(RS_imm), .RS_reg_des_rob(RS_reg_des_rob), .LSB_is_full(LSB_is_full),
    .ROB_store_ready_valid(ROB_store_ready_valid), .ROB_store_ready_tag(ROB_store_ready_tag),
    .ROB_commit_valid(ROB_commit_valid), .ROB_commit_tag(ROB_commit_tag),
    .mem_req_valid(mem_req_valid), .mem_is_write(mem_is_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_len(mem_len), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .LSB_cdb_valid(LSB_cdb_valid), .LSB_cdb_tag(LSB_cdb_tag), .LSB_cdb_data(LSB_cdb_data),
    .state_dbg(state_dbg), .count_dbg(count_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]       op;
    logic [31:0]      addr;
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    bit               committed;
  } ent_t;

  ent_t        lsb_q[$];
  logic [31:0] exp_q[$];
  int          pass_cnt = 0, fail_cnt = 0, total_cnt = 0;

  function automatic bit is_store(input logic [2:0] op);
    return op == SB || op == SH || op == SW;
  endfunction

  function automatic logic [1:0] len_of(input logic [2:0] op);
    if (op == LB || op == LBU || op == SB) return 2'd0;
    if (op == LH || op == LHU || op == SH) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [31:0] load_result(input logic [2:0] op, input logic [31:0] raw);
    int v;
    case (op)
      LB:  begin v = int'(raw & 32'hFF);   if (v >= 128)   v = v - 256;   return v; end
      LH:  begin v = int'(raw & 32'hFFFF); if (v >= 32768) v = v - 65536; return v; end
      LBU: return raw & 32'hFF;
      LHU: return raw & 32'hFFFF;
      default: return raw;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] op, input logic [31:0] r1, input logic [31:0] r2,
                      input logic [31:0] imm, input logic [TAG_W-1:0] tag);
    ent_t e;
    RS_valid = 1'b1; RS_op = op; RS_reg1 = r1; RS_reg2 = r2; RS_imm = imm; RS_reg_des_rob = tag;
    tick();
    RS_valid = 1'b0;
    e.op = op; e.addr = r1 + imm; e.data = r2; e.tag = tag; e.committed = 1'b0;
    lsb_q.push_back(e);
    check("store_ready_valid", ROB_store_ready_valid, is_store(op));
    if (is_store(op)) check("store_ready_tag", ROB_store_ready_tag, tag);
  endtask

  task automatic commit(input logic [TAG_W-1:0] tag);
    ROB_commit_valid = 1'b1; ROB_commit_tag = tag;
    tick();
    ROB_commit_valid = 1'b0;
    foreach (lsb_q[i]) if (is_store(lsb_q[i].op) && lsb_q[i].tag == tag) lsb_q[i].committed = 1'b1;
  endtask

  task automatic do_clear();
    ent_t keep[$];
    clear = 1'b1;
    tick();
    clear = 1'b0;
    foreach (lsb_q[i]) if (lsb_q[i].committed) keep.push_back(lsb_q[i]);
    lsb_q = keep;
    check("clear_cdb_valid", LSB_cdb_valid, 1'b0);
    check("clear_store_ready", ROB_store_ready_valid, 1'b0);
    check("clear_count", count_dbg, lsb_q.size());
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (!mem_req_valid && n < 40) begin
      tick();
      n++;
    end
    check("req_wait_bound", mem_req_valid, 1'b1);
  endtask

  task automatic quiet(input int cycles, input string name);
    int hits = 0;
    repeat (cycles) begin
      tick();
      if (mem_req_valid || LSB_cdb_valid) hits++;
    end
    check(name, hits, 0);
  endtask

  task automatic check_zero(input string name);
    check({name, "_req"}, mem_req_valid, 1'b0);
    check({name, "_is_write"}, mem_is_write, 1'b0);
    check({name, "_addr"}, mem_addr, 32'd0);
    check({name, "_wdata"}, mem_wdata, 32'd0);
    check({name, "_len"}, mem_len, 2'd0);
    check({name, "_full"}, LSB_is_full, 1'b0);
    check({name, "_sr_valid"}, ROB_store_ready_valid, 1'b0);
    check({name, "_sr_tag"}, ROB_store_ready_tag, '0);
    check({name, "_cdb_valid"}, LSB_cdb_valid, 1'b0);
    check({name, "_cdb_tag"}, LSB_cdb_tag, '0);
    check({name, "_cdb_data"}, LSB_cdb_data, 32'd0);
    check({name, "_count"}, count_dbg, 4'd0);
    check({name, "_state"}, state_dbg, 1'b0);
  endtask

  // Serves the head request: checks it against the model front, then completes it.
  task automatic serve(input int lat, input logic [31:0] rdata, input int exp_wait);
    int n;
    ent_t e;
    wait_req(n);
    if (exp_wait >= 0) check("issue_wait", n, exp_wait);
    if (lsb_q.size() == 0) begin
      total_cnt++;
      fail_cnt++;
      $error("FAIL serve_model: observed request expected none");
      return;
    end
    e = lsb_q.pop_front();
    check("mem_addr", mem_addr, e.addr);
    check("mem_len", mem_len, len_of(e.op));
    check("mem_is_write", mem_is_write, is_store(e.op));
    if (is_store(e.op)) check("mem_wdata", mem_wdata, e.data);
    for (int c = 1; c < lat; c++) begin
      tick();
      check("req_held", mem_req_valid, 1'b1);
      check("addr_stable", mem_addr, e.addr);
    end
    mem_done = 1'b1; mem_rdata = rdata;
    tick();
    mem_done = 1'b0; mem_rdata = $urandom;
    check("req_drop", mem_req_valid, 1'b0);
    if (!is_store(e.op)) exp_q.push_back(load_result(e.op, rdata));
    check("cdb_valid", LSB_cdb_valid, !is_store(e.op));
    if (exp_q.size() > 0) begin
      check("cdb_tag", LSB_cdb_tag, e.tag);
      check("cdb_data", LSB_cdb_data, exp_q.pop_front());
    end
    tick();
    check("cdb_one_pulse", LSB_cdb_valid, 1'b0);
  endtask

  initial begin
    int n;
    int tags[$];
    logic [TAG_W-1:0] tag_ctr;

    rst = 1'b1; rdy = 1'b0; clear = 1'b1;
    RS_valid = 1'b1; RS_op = SW; RS_reg1 = 32'h10; RS_reg2 = 32'h20; RS_imm = 32'h4;
    RS_reg_des_rob = 4'd6; ROB_commit_valid = 1'b0; ROB_commit_tag = '0;
    mem_done = 1'b0; mem_rdata = '0;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0; rdy = 1'b1; clear = 1'b0; RS_valid = 1'b0;
    tick();
    check("post_reset_count", count_dbg, 4'd0);

    // LW with base+offset, three-cycle memory
    push(LW, 32'h100, 32'h0, 32'h4, 4'd3);
    serve(3, 32'hDEADBEEF, 1);

    // Sign- and zero-extended byte loads, in order
    push(LB, 32'h300, 32'h0, 32'h0, 4'd1);
    push(LBU, 32'h300, 32'h0, 32'h1, 4'd2);
    serve(2, 32'h00000080, -1);
    serve(1, 32'h00000080, -1);

    // rdy low freezes an in-flight load even with mem_done asserted
    push(LH, 32'h400, 32'h0, 32'h2, 4'd7);
    wait_req(n);
    rdy = 1'b0; mem_done = 1'b1; mem_rdata = 32'h0000FFFF;
    tick(); tick();
    check("freeze_req", mem_req_valid, 1'b1);
    check("freeze_cdb", LSB_cdb_valid, 1'b0);
    check("freeze_count", count_dbg, 4'd1);
    rdy = 1'b1; mem_done = 1'b0;
    serve(2, 32'h00008001, 0);

    // Store waits for its commit; a foreign commit tag is ignored
    push(SW, 32'h200, 32'h12345678, 32'h8, 4'd5);
    quiet(4, "store_before_commit");
    commit(4'd9);
    quiet(3, "store_wrong_commit");
    commit(4'd5);
    serve(2, $urandom, 1);

    // Fill to eight entries with memory stalled
    for (int i = 0; i < 8; i++) begin
      push(LW, 32'h1000, 32'h0, 32'(i * 4), 4'(i));
      check("fill_full", LSB_is_full, (i + 1) >= 7);
      check("fill_count", count_dbg, i + 1);
    end
    while (lsb_q.size() > 0) serve($urandom_range(1, 3), $urandom, -1);

    // Random bursts of mixed loads and stores
    tag_ctr = '0;
    repeat (5) begin
      int k = $urandom_range(3, 7);
      tags.delete();
      for (int j = 0; j < k; j++) begin
        logic [2:0] op = 3'($urandom_range(0, 7));
        push(op, $urandom, $urandom, $urandom, tag_ctr);
        if (is_store(op)) tags.push_back(int'(tag_ctr));
        tag_ctr = tag_ctr + 1'b1;
        check("burst_full", LSB_is_full, lsb_q.size() >= 7);
      end
      foreach (tags[t]) commit(TAG_W'(tags[t]));
      while (lsb_q.size() > 0) serve($urandom_range(1, 4), $urandom, -1);
    end

    // Entry offered together with a flush is discarded
    RS_valid = 1'b1; RS_op = SW; RS_reg_des_rob = 4'd8;
    do_clear();
    RS_valid = 1'b0;
    quiet(3, "discarded_entry");

    // Flush during an in-flight load
    push(LW, 32'h500, 32'h0, 32'h0, 4'd10);
    wait_req(n);
    do_clear();
    check("clear_load_req", mem_req_valid, 1'b0);
    quiet(4, "cleared_load");

    // Flush with committed store in flight and two loads queued
    push(SW, 32'h600, 32'hCAFEF00D, 32'h0, 4'd11);
    push(LW, 32'h604, 32'h0, 32'h0, 4'd12);
    push(LH, 32'h608, 32'h0, 32'h0, 4'd13);
    commit(4'd11);
    wait_req(n);
    do_clear();
    check("clear_store_req", mem_req_valid, 1'b1);
    serve(2, $urandom, 0);
    check("clear_store_count", count_dbg, 4'd0);
    quiet(5, "flushed_loads");

    // Reset in the middle of a load
    push(LW, 32'h700, 32'h0, 32'h0, 4'd14);
    wait_req(n);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lsb_q.delete();
    exp_q.delete();
    check_zero("mid_reset");

    push(LHU, 32'h800, 32'h0, 32'h2, 4'd15);
    serve(1, 32'hABCD8001, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
